// File: rtl/spi_transaction_fsm.sv
// spi_transaction_fsm
// SPI slave transaction sequencer. It decodes one address byte, {addr[6:0], rw},
// from the conditioned SPI inputs. It then either receives one data byte and
// issues a single write strobe to a 128x8 memory, or loads one byte from the
// memory and shifts it out on MISO, MSB first.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cs_cond    conditioned chip select, active low
//   sclk_pos   one-clk pulse on conditioned SCLK rising edge
//   sclk_neg   one-clk pulse on conditioned SCLK falling edge
//   mosi_cond  conditioned MOSI level
//   rd_data    memory read data, valid one clk after addr changes
//   addr       registered memory address
//   wr_en      one-clk memory write strobe
//   wr_data    registered memory write data
//   miso       serial read data, always tx[7]
//   miso_oe    MISO drive enable
//
// state      | meaning
// IDLE       | waiting for chip select low
// GET_ADDR   | shifting in the address/rw byte
// LOAD_READ  | one clk: capture rd_data into tx, enable MISO
// READ       | shifting tx out on MISO
// WRITE      | shifting in the data byte
// DONE       | transaction complete, waiting for chip select high

module spi_transaction_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_cond,
    input  logic       sclk_pos,
    input  logic       sclk_neg,
    input  logic       mosi_cond,
    input  logic [7:0] rd_data,
    output logic [6:0] addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       miso,
    output logic       miso_oe
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ADDR  = 3'd1,
        LOAD_READ = 3'd2,
        READ      = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] rx, rx_nxt;
    logic [7:0] tx, tx_nxt;
    logic [6:0] addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       wr_en_nxt;
    logic       miso_oe_nxt;
    logic [7:0] rx_shift;
    logic       last_bit;

    assign rx_shift = {rx[6:0], mosi_cond};
    assign last_bit = (bit_cnt == 3'd7);
    assign miso     = tx[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            rx      <= 8'h00;
            tx      <= 8'h00;
            addr    <= 7'h00;
            wr_data <= 8'h00;
            wr_en   <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            rx      <= rx_nxt;
            tx      <= tx_nxt;
            addr    <= addr_nxt;
            wr_data <= wr_data_nxt;
            wr_en   <= wr_en_nxt;
            miso_oe <= miso_oe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        rx_nxt      = rx;
        tx_nxt      = tx;
        addr_nxt    = addr;
        wr_data_nxt = wr_data;
        wr_en_nxt   = 1'b0;
        miso_oe_nxt = miso_oe;

        // Chip select release aborts everything, including a byte that
        // completes in this same clk.
        if (cs_cond) begin
            state_nxt   = IDLE;
            miso_oe_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = GET_ADDR;
                    bit_cnt_nxt = 3'd0;
                    rx_nxt      = 8'h00;
                end
                GET_ADDR: begin
                    if (sclk_pos) begin
                        rx_nxt      = rx_shift;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            addr_nxt    = rx_shift[7:1];
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = rx_shift[0] ? LOAD_READ : WRITE;
                        end
                    end
                end
                LOAD_READ: begin
                    tx_nxt      = rd_data;
                    miso_oe_nxt = 1'b1;
                    state_nxt   = READ;
                end
                READ: begin
                    // A rising edge takes precedence over a falling edge
                    // flagged in the same clk. No shift happens before the
                    // first rising edge, so bit 7 stays on MISO until the
                    // master has sampled it.
                    if (sclk_pos) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            bit_cnt_nxt = 3'd0;
                            miso_oe_nxt = 1'b0;
                            state_nxt   = DONE;
                        end
                    end else if (sclk_neg && (bit_cnt != 3'd0)) begin
                        tx_nxt = {tx[6:0], 1'b0};
                    end
                end
                WRITE: begin
                    if (sclk_pos) begin
                        rx_nxt      = rx_shift;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (last_bit) begin
                            wr_data_nxt = rx_shift;
                            wr_en_nxt   = 1'b1;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = DONE;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
